// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and MMIO offsets for the mips_mem unit
//
// Purpose : common scalar typedefs plus the byte offsets of the two MMIO words
//           relative to MMIO_BASE.
// Contents: u1, u32, MMIO_IO_OUT_OFF, MMIO_CYCLE_OFF
package mips_mem_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  localparam u32 MMIO_IO_OUT_OFF = 32'd0;
  localparam u32 MMIO_CYCLE_OFF  = 32'd4;

endpackage

// File: rtl/mips_mem_ram.sv
// rtl/mips_mem_ram.sv - word RAM with two async read ports and a muxed sync write port
//
// Purpose : DEPTH_WORDS x 32 storage for mips_mem. Port a serves the shared
//           data/fetch address, port b always serves the pc so the IR can be
//           loaded while iord steers port a to aluout.
// Ports   : clk                                     clock
//           load_en, load_addr, load_data           preload write (wins over store)
//           st_en, st_addr, st_data                 core store write
//           raddr_a/rdata_a, raddr_b/rdata_b        combinational reads
module mips_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  u32            load_data,
  input  logic          st_en,
  input  logic [AW-1:0] st_addr,
  input  u32            st_data,
  input  logic [AW-1:0] raddr_a,
  output u32            rdata_a,
  input  logic [AW-1:0] raddr_b,
  output u32            rdata_b
);

  u32 mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (st_en) begin
      mem[st_addr] <= st_data;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mips_mem.sv
// rtl/mips_mem.sv - unified instruction/data memory with MMIO window for the multicycle MIPS core
//
// Purpose : address mux, region decode, IR and MDR registers, MMIO output port,
//           free-running cycle counter and sticky error flags around mips_ram.
// Ports   : clk, reset (sync, active-low)
//           core side : iord, memwrite, irwrite, pc, aluout, writedata -> instr, readdata
//           preload   : load_en, load_addr, load_data
//           status    : io_out, io_valid, cycle_count, misalign_err, oob_err
module mips_mem
  import mips_mem_pkg::*;
#(
  parameter int       DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int       AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iord,
  input  logic          memwrite,
  input  logic          irwrite,
  input  u32            pc,
  input  u32            aluout,
  input  u32            writedata,
  output u32            instr,
  output u32            readdata,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  u32            load_data,
  output u32            io_out,
  output logic          io_valid,
  output u32            cycle_count,
  output logic          misalign_err,
  output logic          oob_err
);

  localparam u32 RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam u32 IO_ADDR   = MMIO_BASE + MMIO_IO_OUT_OFF;
  localparam u32 CYC_ADDR  = MMIO_BASE + MMIO_CYCLE_OFF;

  u32 addr, addr_al, pc_al, ram_rd, pc_rd, rd;
  u1  ram_hit, is_io, is_cyc, pc_hit, pc_mmio, misal, core_ok;
  u1  st_ok, st_en, io_wr, data_oob, fetch_oob;

  assign addr    = iord ? aluout : pc;
  // Decode on the word-aligned address so a misaligned read returns the aligned word.
  assign addr_al = {addr[31:2], 2'b00};
  assign pc_al   = {pc[31:2], 2'b00};

  assign ram_hit = addr_al < RAM_BYTES;
  assign is_io   = addr_al == IO_ADDR;
  assign is_cyc  = addr_al == CYC_ADDR;
  assign pc_hit  = pc_al < RAM_BYTES;
  assign pc_mmio = (pc_al == IO_ADDR) || (pc_al == CYC_ADDR);
  assign misal   = addr[1:0] != 2'b00;

  // Preload cycles and reset freeze every core-visible effect.
  assign core_ok   = reset && !load_en;
  assign st_ok     = core_ok && memwrite && !misal;
  assign st_en     = st_ok && ram_hit;
  assign io_wr     = st_ok && is_io;
  assign data_oob  = (iord || memwrite) && !ram_hit && !is_io && !is_cyc;
  assign fetch_oob = irwrite && !pc_hit && !pc_mmio;

  mips_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk       (clk),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .st_en     (st_en),
    .st_addr   (addr[AW+1:2]),
    .st_data   (writedata),
    .raddr_a   (addr[AW+1:2]),
    .rdata_a   (ram_rd),
    .raddr_b   (pc[AW+1:2]),
    .rdata_b   (pc_rd)
  );

  always_comb begin
    rd = '0;
    if (ram_hit)     rd = ram_rd;
    else if (is_io)  rd = io_out;
    else if (is_cyc) rd = cycle_count;
  end

  // IR and MDR sample the async read before the RAM write lands, so a
  // same-cycle store to the fetched word yields the old data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr        <= '0;
      readdata     <= '0;
      io_out       <= '0;
      io_valid     <= 1'b0;
      cycle_count  <= '0;
      misalign_err <= 1'b0;
      oob_err      <= 1'b0;
    end else if (!load_en) begin
      readdata    <= rd;
      cycle_count <= cycle_count + 32'd1;
      io_valid    <= io_wr;
      if (irwrite) instr <= pc_hit ? pc_rd : '0;
      if (io_wr) io_out <= writedata;
      if ((iord || memwrite) && misal) misalign_err <= 1'b1;
      if (data_oob || fetch_oob) oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_mem.sv
// tb/tb_mips_mem.sv - scoreboard testbench for mips_mem
module tb_mips_mem;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset, iord, memwrite, irwrite, load_en;
  logic [31:0] pc, aluout, writedata, load_data;
  logic [7:0]  load_addr;
  logic [31:0] instr, readdata, io_out, cycle_count;
  logic        io_valid, misalign_err, oob_err;

  always #5 clk = ~clk;

  mips_mem dut (
    .clk          (clk),
    .reset        (reset),
    .iord         (iord),
    .memwrite     (memwrite),
    .irwrite      (irwrite),
    .pc           (pc),
    .aluout       (aluout),
    .writedata    (writedata),
    .instr        (instr),
    .readdata     (readdata),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .io_out       (io_out),
    .io_valid     (io_valid),
    .cycle_count  (cycle_count),
    .misalign_err (misalign_err),
    .oob_err      (oob_err)
  );

  typedef struct {
    logic [31:0] instr, rd, io, cnt;
    logic        iov, mis, oob;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state
  logic [31:0] mm [256];
  logic [31:0] m_instr = 0, m_rd = 0, m_io = 0, m_cnt = 0;
  logic        m_iov = 0, m_mis = 0, m_oob = 0;

  function automatic logic [31:0] readw(input logic [31:0] aw);
    if (aw < 32'd1024)      return mm[aw >> 2];
    else if (aw == MB)      return m_io;
    else if (aw == MB + 4)  return m_cnt;
    else                    return 32'd0;
  endfunction

  function automatic logic is_mmio(input logic [31:0] aw);
    return (aw == MB) || (aw == MB + 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle and push the model's expectation for the following edge.
  task automatic cyc(input logic rst, input logic ld, input logic [7:0] la, input logic [31:0] ldd,
                     input logic io, input logic mw, input logic ir,
                     input logic [31:0] p, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] ad, aw, pw, n_rd, n_instr, n_io, n_cnt;
    logic        n_iov, n_mis, n_oob, misal, wr_ram;
    exp_t e;
    @(negedge clk);
    reset = rst; load_en = ld; load_addr = la; load_data = ldd;
    iord = io; memwrite = mw; irwrite = ir; pc = p; aluout = a; writedata = w;

    ad    = io ? a : p;
    aw    = ad & ~32'h3;
    pw    = p & ~32'h3;
    misal = (ad[1:0] != 2'b00);
    n_rd = m_rd; n_instr = m_instr; n_io = m_io; n_cnt = m_cnt;
    n_iov = m_iov; n_mis = m_mis; n_oob = m_oob; wr_ram = 0;
    if (!rst) begin
      n_rd = 0; n_instr = 0; n_io = 0; n_cnt = 0; n_iov = 0; n_mis = 0; n_oob = 0;
    end else if (!ld) begin
      n_rd  = readw(aw);
      n_cnt = m_cnt + 1;
      n_iov = 0;
      if (ir) n_instr = (p < 32'd1024) ? mm[p >> 2] : 32'd0;
      if (mw && !misal) begin
        if (aw < 32'd1024) wr_ram = 1;
        else if (aw == MB) begin n_io = w; n_iov = 1; end
      end
      if ((io || mw) && misal) n_mis = 1;
      if ((io || mw) && aw >= 32'd1024 && !is_mmio(aw)) n_oob = 1;
      if (ir && pw >= 32'd1024 && !is_mmio(pw)) n_oob = 1;
    end
    if (ld) mm[la] = ldd;
    else if (rst && wr_ram) mm[aw >> 2] = w;
    m_rd = n_rd; m_instr = n_instr; m_io = n_io; m_cnt = n_cnt;
    m_iov = n_iov; m_mis = n_mis; m_oob = n_oob;
    e.instr = m_instr; e.rd = m_rd; e.io = m_io; e.cnt = m_cnt;
    e.iov = m_iov; e.mis = m_mis; e.oob = m_oob;
    q.push_back(e);
  endtask

  task automatic idle(input logic io, input logic [31:0] a);
    cyc(1, 0, 0, 0, io, 0, 0, 0, a, 0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(0, 9);
    if (r <= 4)      return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else if (r == 5) return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    else if (r == 6) return MB;
    else if (r == 7) return MB + 4;
    else if (r == 8) return 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
    else             return MB + 32'($urandom_range(1, 7));
  endfunction

  // Monitor: compares DUT outputs just after each edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instr",        instr,        e.instr);
        chk("readdata",     readdata,     e.rd);
        chk("io_out",       io_out,       e.io);
        chk("io_valid",     32'(io_valid),     32'(e.iov));
        chk("cycle_count",  cycle_count,  e.cnt);
        chk("misalign_err", 32'(misalign_err), 32'(e.mis));
        chk("oob_err",      32'(oob_err),      32'(e.oob));
      end
    end
  end

  initial begin
    int guard;
    reset = 0; load_en = 0; load_addr = 0; load_data = 0;
    iord = 0; memwrite = 0; irwrite = 0; pc = 0; aluout = 0; writedata = 0;

    // Preload the whole RAM while held in reset.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'h2002_0005 : (i == 2) ? 32'h1111_1111 : $urandom;
      cyc(0, 1, 8'(i), v, 0, 0, 0, 0, 0, 0);
    end

    // Fetch of preloaded word.
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    // Store then load back.
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 32'h10, 32'hDEAD_BEEF);
    idle(1, 32'h10);
    // MMIO output port and counter readback.
    cyc(1, 0, 0, 0, 1, 1, 0, 0, MB, 32'h0000_002A);
    idle(0, 0);
    idle(1, MB + 4);
    idle(1, MB);
    // Misaligned store dropped, then out-of-range store.
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 32'h12, 32'hBAD0_BAD0);
    idle(1, 32'h10);
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 32'h8000_0000, 32'h5555_5555);
    idle(0, 0);
    // Same-cycle fetch and store to one word.
    cyc(1, 0, 0, 0, 1, 1, 1, 32'h8, 32'h8, 32'h2222_2222);
    idle(1, 32'h8);
    // Reset while io_valid is high, RAM survives.
    cyc(1, 0, 0, 0, 1, 1, 0, 0, MB, 32'h1234_5678);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 32'h10);
    idle(1, 32'h8);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic rst, ld;
      rst = ($urandom_range(0, 79) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      cyc(rst, ld, 8'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), rnd_addr(), rnd_addr(), $urandom);
    end
    idle(0, 0);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
